score_7seg_driver: RTL and testbench

Consumes the 14-bit binary score counter from the pong game core and drives the 4-digit multiplexed 7-segment display. Internally it runs an iterative double-dabble binary-to-BCD conversion FSM, holds the converted digits in a display register, and time-multiplexes the four digits. It sits directly downstream of the game core's score counter, between that counter and the board's SEG7OUT/SEG7COM pins.

---
 rtl/score_disp_pkg.sv | 50 +++++
 rtl/bin14_bcd_dd.sv | 70 +++++++
 rtl/score_7seg_driver.sv | 103 ++++++++++
 tb/tb_score_7seg_driver.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display path: conversion FSM
// states, datapath widths and the 7-segment glyph table.
package score_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } dd_state_t;

  localparam int DIGITS = 4;
  localparam int BCD_W  = 16;
  localparam int BIN_W  = 14;

  localparam logic [BIN_W-1:0] BIN_MAX = 14'd9999;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_PAT [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_PAT[0];
      4'd1:    return SEG_PAT[1];
      4'd2:    return SEG_PAT[2];
      4'd3:    return SEG_PAT[3];
      4'd4:    return SEG_PAT[4];
      4'd5:    return SEG_PAT[5];
      4'd6:    return SEG_PAT[6];
      4'd7:    return SEG_PAT[7];
      4'd8:    return SEG_PAT[8];
      4'd9:    return SEG_PAT[9];
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction step: every BCD nibble >= 5 gets +3
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin14_bcd_dd.sv
// Iterative 14-bit binary to 4-digit BCD converter (double dabble),
// one shift per cycle; input clamped to 9999 with an overflow flag.
module bin14_bcd_dd
  import score_disp_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_ovf
);

  dd_state_t        r_state;
  dd_state_t        w_next;
  logic [BIN_W-1:0] r_bin_sh;
  logic [BCD_W-1:0] r_bcd_sh;
  logic [3:0]       r_cnt;
  logic             r_ovf_n;
  logic [BCD_W-1:0] w_adj;

  assign w_adj = add3_nibbles(r_bcd_sh);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == 4'(BIN_W - 1)) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin_sh <= '0;
      r_bcd_sh <= '0;
      r_cnt    <= '0;
      r_ovf_n  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_bin_sh <= (i_bin > BIN_MAX) ? BIN_MAX : i_bin;
          r_bcd_sh <= '0;
          r_cnt    <= '0;
          r_ovf_n  <= (i_bin > BIN_MAX);
        end
        ST_SHIFT: begin
          {r_bcd_sh, r_bin_sh} <= {w_adj, r_bin_sh} << 1;
          r_cnt                <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Result is presented raw during DONE; the caller latches it on o_done
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_DONE);
  assign o_bcd  = r_bcd_sh;
  assign o_ovf  = r_ovf_n;

endmodule

// File: rtl/score_7seg_driver.sv
// Score to 4-digit multiplexed 7-segment driver: change detect, BCD
// conversion, display register, digit scan and registered pin outputs.
module score_7seg_driver
  import score_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 2000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BIN_W-1:0]  value,
  output logic [6:0]        SEG7OUT,
  output logic [DIGITS-1:0] SEG7COM,
  output logic              ovf,
  output logic              busy
);

  localparam int             PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] COM_OFF = (COM_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [BIN_W-1:0] r_last_val;
  logic [BCD_W-1:0] r_bcd_disp;
  logic             r_ovf;
  logic [PW-1:0]    r_presc;
  logic [1:0]       r_dig;

  logic             w_busy;
  logic             w_done;
  logic             w_start;
  logic [BCD_W-1:0] w_bcd;
  logic             w_ovf_n;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic [6:0]       w_pat;
  logic [DIGITS-1:0] w_onehot;

  assign w_start = !w_busy && (value != r_last_val);

  always_ff @(posedge CLK) begin
    if (RST)          r_last_val <= '0;
    else if (w_start) r_last_val <= value;
  end

  bin14_bcd_dd u_dd (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_start (w_start),
    .i_bin   (value),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_ovf   (w_ovf_n)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bcd_disp <= '0;
      r_ovf      <= 1'b0;
    end else if (w_done) begin
      r_bcd_disp <= w_bcd;
      r_ovf      <= w_ovf_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc <= '0;
      r_dig   <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_dig   <= r_dig + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A digit is leading-zero when it and every higher nibble are zero
  always_comb begin
    w_nib    = r_bcd_disp[{r_dig, 2'b00} +: 4];
    w_blank  = (BLANK_LEADING != 0) && (r_dig != 2'd0) &&
               ((r_bcd_disp >> {r_dig, 2'b00}) == '0);
    w_pat    = w_blank ? SEG_BLANK : seg_decode(w_nib);
    w_onehot = 4'b0001 << r_dig;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG7OUT <= SEG_OFF;
      SEG7COM <= COM_OFF;
    end else begin
      SEG7OUT <= w_pat ^ SEG_OFF;
      SEG7COM <= w_onehot ^ COM_OFF;
    end
  end

  assign busy = w_busy;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_score_7seg_driver.sv
// Self-checking bench: two driver instances (default polarity with blanking,
// inverted polarity without blanking) against an arithmetic display model.
module tb_score_7seg_driver;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [13:0] value = '0;

  logic [6:0] a_seg, b_seg;
  logic [3:0] a_com, b_com;
  logic       a_ovf, b_ovf, a_busy, b_busy;

  always #5 CLK = ~CLK;

  score_7seg_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1), .BLANK_LEADING(1)) dut0 (
    .CLK(CLK), .RST(RST), .value(value),
    .SEG7OUT(a_seg), .SEG7COM(a_com), .ovf(a_ovf), .busy(a_busy)
  );

  score_7seg_driver #(.SCAN_DIV(3), .SEG_ACTIVE_LOW(0), .COM_ACTIVE_LOW(0), .BLANK_LEADING(0)) dut1 (
    .CLK(CLK), .RST(RST), .value(value),
    .SEG7OUT(b_seg), .SEG7COM(b_com), .ovf(b_ovf), .busy(b_busy)
  );

  localparam int SD  [2] = '{4, 3};
  localparam int BLK [2] = '{1, 0};
  localparam int SAL [2] = '{1, 0};
  localparam int CAL [2] = '{1, 0};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] digit_glyph(input int m, input int disp, input int dig);
    int p;
    p = 1;
    for (int i = 0; i < dig; i++) p = p * 10;
    if (BLK[m] != 0 && dig > 0 && disp < p) return 7'h00;
    return glyph((disp / p) % 10);
  endfunction

  // Model: conversion is a 15-cycle busy window after a change is seen
  // while idle; scan position follows from cycles elapsed since reset.
  int   m_last, m_cnt, m_pend, m_disp, m_t;
  bit   m_povf, m_ovf;
  bit   chk_en = 0;
  logic [6:0] e_seg [2];
  logic [3:0] e_com [2];

  always @(posedge CLK) begin
    if (RST) begin
      m_last = 0; m_cnt = 0; m_pend = 0; m_disp = 0; m_ovf = 0; m_povf = 0; m_t = 0;
      for (int m = 0; m < 2; m++) begin
        e_seg[m] = (SAL[m] != 0) ? 7'h7F : 7'h00;
        e_com[m] = (CAL[m] != 0) ? 4'hF : 4'h0;
      end
      chk_en = 1;
    end else begin
      for (int m = 0; m < 2; m++) begin
        int dig;
        logic [6:0] pat;
        logic [3:0] oh;
        dig = (m_t / SD[m]) % 4;
        pat = digit_glyph(m, m_disp, dig);
        oh  = 4'b0001 << dig;
        e_seg[m] = (SAL[m] != 0) ? ~pat : pat;
        e_com[m] = (CAL[m] != 0) ? ~oh : oh;
      end
      if (m_cnt == 0) begin
        if (int'(value) != m_last) begin
          m_last = int'(value);
          m_pend = (value > 14'd9999) ? 9999 : int'(value);
          m_povf = (value > 14'd9999);
          m_cnt  = 15;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_disp = m_pend;
          m_ovf  = m_povf;
        end
      end
      m_t++;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("seg0", a_seg, e_seg[0]);
      chk("com0", a_com, e_com[0]);
      chk("seg1", b_seg, e_seg[1]);
      chk("com1", b_com, e_com[1]);
      chk("busy0", a_busy, m_cnt != 0);
      chk("busy1", b_busy, m_cnt != 0);
      chk("ovf0", a_ovf, m_ovf);
      chk("ovf1", b_ovf, m_ovf);
    end
  end

  task automatic see_digit(input int which, input int k, input logic [6:0] exp, input string nm);
    logic [3:0] tgt;
    int n;
    tgt = (which == 0) ? ~(4'b0001 << k) : (4'b0001 << k);
    n = 0;
    while (((which == 0) ? a_com : b_com) !== tgt && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_com"}, (which == 0) ? a_com : b_com, tgt);
    chk(nm, (which == 0) ? a_seg : b_seg, exp);
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int n;
    n = 0;
    while (a_busy !== lvl && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, a_busy, lvl);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (a_busy === 1'b1 && n < 40) begin
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int n;
    logic [3:0] c;

    // Reset held three edges
    repeat (3) @(negedge CLK);
    chk("rst_com0", a_com, 4'b1111);
    chk("rst_seg0", a_seg, 7'b1111111);
    chk("rst_com1", b_com, 4'b0000);
    chk("rst_seg1", b_seg, 7'b0000000);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_com0", a_com, 4'b1110);
    chk("post_seg0", a_seg, 7'b1000000);
    chk("post_busy", a_busy, 1'b0);
    see_digit(0, 1, 7'h7F, "zero_d1");
    see_digit(0, 2, 7'h7F, "zero_d2");
    see_digit(0, 3, 7'h7F, "zero_d3");
    see_digit(1, 2, 7'h3F, "zero_nb_d2");

    // 1234: 15-cycle busy window, then 4,3,2,1 each held 4 cycles
    value = 14'd1234;
    @(negedge CLK);
    busy_len(n);
    chk("busy_len_1234", n, 15);
    @(negedge CLK);
    see_digit(0, 1, 7'h30, "d1_1234");
    see_digit(0, 2, 7'h24, "d2_1234");
    see_digit(0, 3, 7'h79, "d3_1234");
    see_digit(0, 0, 7'h19, "d0_1234");
    c = a_com;
    n = 0;
    while (a_com === c && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk("slot_hold", n, 4);
    chk("ovf_1234", a_ovf, 1'b0);

    // Overflow clamps to 9999
    value = 14'd10000;
    wait_busy(1'b1, "ovf_busy_hi");
    wait_busy(1'b0, "ovf_busy_lo");
    @(negedge CLK);
    chk("ovf_set", a_ovf, 1'b1);
    for (int k = 0; k < 4; k++) see_digit(0, k, 7'h10, "d_9999");

    value = 14'd7;
    wait_busy(1'b1, "seven_busy_hi");
    wait_busy(1'b0, "seven_busy_lo");
    @(negedge CLK);
    chk("ovf_clr", a_ovf, 1'b0);
    see_digit(0, 0, 7'h78, "d0_7");
    see_digit(0, 1, 7'h7F, "d1_7");
    see_digit(0, 2, 7'h7F, "d2_7");
    see_digit(0, 3, 7'h7F, "d3_7");
    see_digit(1, 1, 7'h3F, "nb_d1_7");

    // Change 5 -> 6 mid-shift: one idle cycle between the two conversions
    value = 14'd5;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    value = 14'd6;
    busy_len(n);
    chk("busy_len_5", n + 2, 15);
    n = 0;
    while (a_busy === 1'b0 && n < 10) begin
      n++;
      @(negedge CLK);
    end
    chk("idle_gap", n, 1);
    busy_len(n);
    chk("busy_len_6", n, 15);
    @(negedge CLK);
    see_digit(0, 0, 7'h02, "d0_6");

    // Reset mid-conversion with 42 held
    value = 14'd42;
    @(negedge CLK);
    repeat (4) @(negedge CLK);
    chk("mid_busy", a_busy, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_abort", a_busy, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    chk("restart", a_busy, 1'b1);
    repeat (14) @(negedge CLK);
    chk("restart_busy14", a_busy, 1'b1);
    @(negedge CLK);
    chk("r15_busy", a_busy, 1'b0);
    chk("r15_com0", a_com, 4'b0111);
    chk("r15_seg0", a_seg, 7'h7F);
    chk("r15_seg1", b_seg, 7'h3F);
    @(negedge CLK);
    chk("r16_com0", a_com, 4'b1110);
    chk("r16_seg0", a_seg, 7'h24);
    chk("r16_com1", b_com, 4'b0010);
    chk("r16_seg1", b_seg, 7'h66);

    // No leading-zero blanking on the second instance
    value = 14'd100;
    wait_busy(1'b1, "h_busy_hi");
    wait_busy(1'b0, "h_busy_lo");
    @(negedge CLK);
    see_digit(1, 0, 7'h3F, "nb_d0_100");
    see_digit(1, 1, 7'h3F, "nb_d1_100");
    see_digit(1, 2, 7'h06, "nb_d2_100");
    see_digit(1, 3, 7'h3F, "nb_d3_100");

    // Randomized values, hold times and reset pulses
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0: value = 14'd9999;
        1: value = 14'd10000 + 14'($urandom_range(0, 6383));
        2: value = 14'($urandom_range(0, 20));
        default: value = 14'($urandom_range(0, 16383));
      endcase
      if ($urandom_range(0, 11) == 0) begin
        RST = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge CLK);
        RST = 1'b0;
      end
      repeat ($urandom_range(1, 40)) @(negedge CLK);
    end
    repeat (40) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
